// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words,
// compares them with expected values and latches a boot pass/fail verdict.
module sysid_boot_checker #(
    parameter int unsigned        ADDR_W         = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR      = '0,
    parameter logic [31:0]        EXPECTED_ID    = 32'd0,
    parameter logic [31:0]        EXPECTED_TS    = 32'd1637051090,
    parameter int unsigned        TIMEOUT_CYCLES = 1024,
    parameter bit                 AUTO_START     = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              pass,
    output logic              timeout_err,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID_REQ,
        S_RD_ID_WAIT,
        S_RD_TS_REQ,
        S_RD_TS_WAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] TS_ADDR = BASE_ADDR + ADDR_W'(4);
    localparam bit                WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0]       WD_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        auto_pending;
    logic [15:0] wd_cnt;
    logic        wd_last;
    logic        wd_clear;
    logic        clr_results;
    logic        cap_id;
    logic        cap_ts;
    logic        set_timeout;

    // True in the TIMEOUT_CYCLES-th counted cycle of the current transaction.
    assign wd_last = WD_EN && (wd_cnt == WD_LAST);
    assign pass    = id_ok & ts_ok & ~timeout_err;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            auto_pending <= AUTO_START;
        end else begin
            state        <= state_next;
            auto_pending <= 1'b0;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next  = state;
        wd_clear    = 1'b0;
        clr_results = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (start || auto_pending) begin
                    state_next  = S_RD_ID_REQ;
                    wd_clear    = 1'b1;
                    clr_results = 1'b1;
                end
            end
            S_RD_ID_REQ: begin
                if (!avm_waitrequest) begin
                    state_next = S_RD_ID_WAIT;
                end else if (wd_last) begin
                    state_next  = S_DONE;
                    set_timeout = 1'b1;
                end
            end
            S_RD_ID_WAIT: begin
                if (avm_readdatavalid) begin
                    state_next = S_RD_TS_REQ;
                    cap_id     = 1'b1;
                    wd_clear   = 1'b1;
                end else if (wd_last) begin
                    state_next  = S_DONE;
                    set_timeout = 1'b1;
                end
            end
            S_RD_TS_REQ: begin
                if (!avm_waitrequest) begin
                    state_next = S_RD_TS_WAIT;
                end else if (wd_last) begin
                    state_next  = S_DONE;
                    set_timeout = 1'b1;
                end
            end
            S_RD_TS_WAIT: begin
                if (avm_readdatavalid) begin
                    state_next = S_DONE;
                    cap_ts     = 1'b1;
                end else if (wd_last) begin
                    state_next  = S_DONE;
                    set_timeout = 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they only move on
    // clock edges and stay frozen while the slave stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            avm_read    <= 1'b0;
            avm_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wd_cnt      <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            avm_read    <= (state_next == S_RD_ID_REQ) || (state_next == S_RD_TS_REQ);
            avm_address <= (state_next == S_RD_TS_REQ) ? TS_ADDR :
                           (state_next == S_RD_ID_REQ) ? BASE_ADDR : '0;
            busy        <= !(state_next inside {S_IDLE, S_DONE});
            done        <= (state_next == S_DONE);

            if (wd_clear) begin
                wd_cnt <= '0;
            end else if (state inside {S_RD_ID_REQ, S_RD_ID_WAIT, S_RD_TS_REQ, S_RD_TS_WAIT}) begin
                wd_cnt <= wd_cnt + 16'd1;
            end

            if (clr_results) begin
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b0;
                id_value    <= '0;
                ts_value    <= '0;
            end
            if (cap_id) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (cap_ts) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TS);
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomized scoreboard bench for sysid_boot_checker: a bus-level slave model
// drives stalls and data, a reference model predicts each check's verdict.
module tb_sysid_boot_checker;

    localparam int unsigned ADDR_W  = 32;
    localparam logic [31:0] BASE    = 32'h0000_2000;
    localparam logic [31:0] EXP_ID  = 32'hA5C3_0017;
    localparam logic [31:0] EXP_TS  = 32'd1637051090;
    localparam int          T       = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest = 1'b0;
    logic [31:0]       avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic              busy, done, id_ok, ts_ok, pass, timeout_err;
    logic [31:0]       id_value, ts_value;

    sysid_boot_checker #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .EXPECTED_ID(EXP_ID),
        .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .pass(pass),
        .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [31:0] id_value;
        logic [31:0] ts_value;
        logic        id_ok;
        logic        ts_ok;
        logic        pass;
        logic        timeout_err;
        int          done_cycle;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    // Slave configuration for the check in flight: index 0 = ID read, 1 = TS read.
    logic [31:0] cfg_word[2];
    int          cfg_w[2];
    int          cfg_v[2];
    bit          cfg_nr[2];
    int          check_seq = 0;

    // Reference model: each read occupies (stall + 1) request cycles plus
    // (latency + 1) wait cycles; a silent slave aborts T cycles into its read.
    function automatic exp_t predict(input int c0, input logic [31:0] idw, input logic [31:0] tsw,
                                     input int w0, input int v0, input int w1, input int v1,
                                     input bit nr0, input bit nr1);
        exp_t e;
        int   s0, s1;
        e = '{id_value: 32'd0, ts_value: 32'd0, id_ok: 1'b0, ts_ok: 1'b0,
              pass: 1'b0, timeout_err: 1'b0, done_cycle: 0};
        s0 = c0 + 1;
        if (nr0) begin
            e.timeout_err = 1'b1;
            e.done_cycle  = s0 + T;
        end else begin
            e.id_value = idw;
            e.id_ok    = (idw == EXP_ID);
            s1 = s0 + w0 + v0 + 2;
            if (nr1) begin
                e.timeout_err = 1'b1;
                e.done_cycle  = s1 + T;
            end else begin
                e.ts_value   = tsw;
                e.ts_ok      = (tsw == EXP_TS);
                e.done_cycle = s1 + w1 + v1 + 2;
            end
        end
        e.pass = e.id_ok && e.ts_ok && !e.timeout_err;
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    e = sb.pop_front();
                    last_exp = e;
                    check("done_cycle", cyc, e.done_cycle);
                    check("id_ok", id_ok, e.id_ok);
                    check("ts_ok", ts_ok, e.ts_ok);
                    check("pass", pass, e.pass);
                    check("timeout_err", timeout_err, e.timeout_err);
                    check("id_value", id_value, e.id_value);
                    check("ts_value", ts_value, e.ts_value);
                end
            end
        end
    end

    // Slave model: applies stalls, returns data, checks bus protocol.
    initial begin
        int seen_seq = 0, rd_idx = 0, idx = 0, pend = -1, pend_idx = 0, stall_left = 0;
        bit prev_read = 1'b0, outstanding = 1'b0, accepted_prev = 1'b0;
        logic [31:0] prev_addr = '0;
        forever begin
            @(posedge clock);
            #2;
            if (reset) begin
                avm_waitrequest = 1'b0;
                avm_readdatavalid = 1'b0;
                pend = -1;
                outstanding = 1'b0;
                prev_read = 1'b0;
                accepted_prev = 1'b0;
                continue;
            end
            if (check_seq != seen_seq) begin
                seen_seq = check_seq;
                rd_idx = 0;
            end
            if (!busy) outstanding = 1'b0;
            if (accepted_prev) check("read_drop", avm_read, 1'b0);
            accepted_prev = 1'b0;

            avm_readdatavalid = 1'b0;
            avm_readdata = $urandom;
            if (pend == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = cfg_word[pend_idx];
                pend = -1;
                outstanding = 1'b0;
            end else if (pend > 0) begin
                pend--;
            end else if ((!busy || (avm_read && !outstanding)) && $urandom_range(3) == 0) begin
                avm_readdatavalid = 1'b1;   // must be ignored outside WAIT states
            end

            if (avm_read) begin
                idx = (rd_idx > 1) ? 1 : rd_idx;
                check("busy_in_req", busy, 1'b1);
                if (prev_read) check("addr_stable", avm_address, prev_addr);
                else stall_left = cfg_w[idx];
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    check("read_addr", avm_address, BASE + 32'(4 * rd_idx));
                    if (!cfg_nr[idx]) begin
                        pend = cfg_v[idx];
                        pend_idx = idx;
                        outstanding = 1'b1;
                    end
                    rd_idx++;
                    accepted_prev = 1'b1;
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(1));
            end
            prev_read = avm_read;
            prev_addr = avm_address;
        end
    end

    task automatic set_cfg(input logic [31:0] idw, input logic [31:0] tsw,
                           input int w0, input int v0, input int w1, input int v1,
                           input bit nr0, input bit nr1);
        cfg_word[0] = idw;  cfg_word[1] = tsw;
        cfg_w[0] = w0;      cfg_w[1] = w1;
        cfg_v[0] = v0;      cfg_v[1] = v1;
        cfg_nr[0] = nr0;    cfg_nr[1] = nr1;
        sb.push_back(predict(cyc, idw, tsw, w0, v0, w1, v1, nr0, nr1));
        check_seq++;
    endtask

    // Called at #1 after an edge; that cycle is cycle 0 of the check.
    task automatic issue_check(input logic [31:0] idw, input logic [31:0] tsw,
                               input int w0, input int v0, input int w1, input int v1,
                               input bit nr0, input bit nr1);
        set_cfg(idw, tsw, w0, v0, w1, v1, nr0, nr1);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n0;
        n0 = n_done;
        for (int i = 0; i < 200 && n_done == n0; i++) @(posedge clock);
        #1;
        check("done_seen", n_done - n0, 1);
        check("idle_busy", busy, 1'b0);
        check("hold_id_value", id_value, last_exp.id_value);
        check("hold_pass", pass, last_exp.pass);
    endtask

    task automatic check_all_zero();
        check("rst_avm_read", avm_read, 1'b0);
        check("rst_avm_address", avm_address, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_id_ok", id_ok, 1'b0);
        check("rst_ts_ok", ts_ok, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_id_value", id_value, 0);
        check("rst_ts_value", ts_value, 0);
    endtask

    // Reset, verify cleared outputs, then release so AUTO_START runs a check.
    task automatic reset_and_autorun(input logic [31:0] idw, input logic [31:0] tsw,
                                     input int w0, input int v0, input int w1, input int v1);
        reset = 1'b1;
        start = 1'b0;
        sb.delete();
        @(posedge clock);
        #1;
        check_all_zero();
        @(posedge clock);
        #1;
        check_all_zero();
        set_cfg(idw, tsw, w0, v0, w1, v1, 1'b0, 1'b0);
        reset = 1'b0;
        wait_done();
    endtask

    initial begin
        #(10 * 20000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] idw, tsw;
        #1;
        reset_and_autorun(EXP_ID, EXP_TS, 0, 0, 0, 0);

        issue_check(EXP_ID, EXP_TS, 0, 0, 0, 0, 1'b0, 1'b0);
        wait_done();
        issue_check(EXP_ID, EXP_TS + 32'd1, 0, 0, 0, 0, 1'b0, 1'b0);
        wait_done();
        issue_check(EXP_ID, EXP_TS, 3, 0, 3, 0, 1'b0, 1'b0);
        wait_done();
        issue_check(EXP_ID, EXP_TS, 0, 0, 0, 0, 1'b1, 1'b0);
        wait_done();
        issue_check(EXP_ID ^ 32'h1, EXP_TS, 2, 1, 0, 0, 1'b0, 1'b1);
        wait_done();

        // Extra start during RD_TS_WAIT must be dropped, not queued.
        issue_check(EXP_ID, EXP_TS, 0, 0, 0, 3, 1'b0, 1'b0);
        repeat (4) begin @(posedge clock); #1; end
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done();
        repeat (10) begin @(posedge clock); #1; end
        check("no_queued_start", busy, 1'b0);

        // Reset while the ID request is stalled, then the automatic rerun.
        issue_check(EXP_ID, EXP_TS, 5, 0, 0, 0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset_and_autorun(EXP_ID, EXP_TS, 0, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            idw = ($urandom_range(1) == 0) ? EXP_ID : $urandom;
            tsw = ($urandom_range(1) == 0) ? EXP_TS : $urandom;
            repeat ($urandom_range(3)) begin @(posedge clock); #1; end
            issue_check(idw, tsw, $urandom_range(3), $urandom_range(2), $urandom_range(3),
                        $urandom_range(2), ($urandom_range(9) == 0), ($urandom_range(9) == 0));
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
